// File: rtl/ras_ctrl_pkg.sv
// Shared fetch-unit definitions for the return-address stack: RASCTL encodings,
// default geometry and the return-address helper used by decoder and controller.
package ras_ctrl_pkg;

  localparam int RAS_DEPTH = 16;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W = RAS_PTR_W + 1;
  localparam int RAS_ADDR_W = 64;

  typedef enum logic [1:0] {
    RAS_NONE    = 2'b00,
    RAS_PUSH    = 2'b01,
    RAS_POP     = 2'b10,
    RAS_POPPUSH = 2'b11
  } rasctl_e;

  // Calls are fixed 4-byte instructions; the carry out of bit 63 is dropped.
  function automatic logic [RAS_ADDR_W-1:0] ras_ret_addr(input logic [RAS_ADDR_W-1:0] pc);
    return pc + RAS_ADDR_W'(4);
  endfunction

endpackage

// File: rtl/ras_ctrl_if.sv
// F1 decoder / back-end recovery bundle into the RAS controller, plus the
// prediction and checkpoint outputs returned to fetch.
interface ras_ctrl_if
  import ras_ctrl_pkg::*;
#(
  parameter int PTR_W = RAS_PTR_W,
  parameter int CNT_W = RAS_CNT_W
);

  logic                  brdec_brext_f1_i;
  logic [1:0]            brdec_rasctl_f1_i;
  logic [RAS_ADDR_W-1:0] brdec_rasdat_f1_i;
  logic                  flush_vld_i;
  logic                  rcv_vld_i;
  logic [PTR_W-1:0]      rcv_tos_i;
  logic [CNT_W-1:0]      rcv_cnt_i;
  logic [RAS_ADDR_W-1:0] ras_pcdata_f0_o;
  logic                  ras_empty_o;
  logic [PTR_W-1:0]      ras_tos_f1_o;
  logic [CNT_W-1:0]      ras_cnt_f1_o;

  modport master (
    output brdec_brext_f1_i,
    output brdec_rasctl_f1_i,
    output brdec_rasdat_f1_i,
    output flush_vld_i,
    output rcv_vld_i,
    output rcv_tos_i,
    output rcv_cnt_i,
    input  ras_pcdata_f0_o,
    input  ras_empty_o,
    input  ras_tos_f1_o,
    input  ras_cnt_f1_o
  );

  modport slave (
    input  brdec_brext_f1_i,
    input  brdec_rasctl_f1_i,
    input  brdec_rasdat_f1_i,
    input  flush_vld_i,
    input  rcv_vld_i,
    input  rcv_tos_i,
    input  rcv_cnt_i,
    output ras_pcdata_f0_o,
    output ras_empty_o,
    output ras_tos_f1_o,
    output ras_cnt_f1_o
  );

endinterface

// File: rtl/ras_stack.sv
// Return-address register file: one synchronous write port, one asynchronous
// read port, synchronous reset of every entry to zero.
module ras_stack
  import ras_ctrl_pkg::*;
#(
  parameter int DEPTH  = RAS_DEPTH,
  parameter int IDX_W  = RAS_PTR_W,
  parameter int DATA_W = RAS_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) begin
      mem_d[wr_idx_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: circular stack of predicted return addresses
// with per-bundle tos/cnt checkpoints and checkpoint restore on recovery.
module ras_ctrl
  import ras_ctrl_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH,
  parameter int PTR_W = RAS_PTR_W,
  parameter int CNT_W = RAS_CNT_W
) (
  input  logic     clk_i,
  input  logic     rst_i,
  ras_ctrl_if.slave bus
);

  logic [PTR_W-1:0]      tos_q, tos_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_en;
  logic [PTR_W-1:0]      wr_idx;
  logic [RAS_ADDR_W-1:0] ret_addr;
  logic [RAS_ADDR_W-1:0] top_data;
  logic                  upd_en;
  logic                  cnt_zero;
  logic                  cnt_full;
  rasctl_e               op;

  assign ret_addr = ras_ret_addr(bus.brdec_rasdat_f1_i);
  assign op       = rasctl_e'(bus.brdec_rasctl_f1_i);
  assign cnt_zero = (cnt_q == '0);
  assign cnt_full = (cnt_q == CNT_W'(DEPTH));
  assign upd_en   = bus.brdec_brext_f1_i & ~bus.flush_vld_i & ~bus.rcv_vld_i;

  // Recovery outranks flush, which outranks the F1 update; reset is applied in the flops.
  always_comb begin
    tos_d  = tos_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = tos_q;
    if (bus.rcv_vld_i) begin
      tos_d = bus.rcv_tos_i;
      cnt_d = bus.rcv_cnt_i;
    end else if (upd_en) begin
      case (op)
        RAS_PUSH: begin
          tos_d  = tos_q + PTR_W'(1);
          wr_en  = 1'b1;
          wr_idx = tos_q + PTR_W'(1);
          cnt_d  = cnt_full ? cnt_q : cnt_q + CNT_W'(1);
        end
        RAS_POP: begin
          if (!cnt_zero) begin
            tos_d = tos_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        RAS_POPPUSH: begin
          wr_en = 1'b1;
          cnt_d = cnt_zero ? CNT_W'(1) : cnt_q;
        end
        default: begin
          tos_d = tos_q;
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tos_q <= '0;
      cnt_q <= '0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

  ras_stack #(
    .DEPTH  (DEPTH),
    .IDX_W  (PTR_W),
    .DATA_W (RAS_ADDR_W)
  ) u_stack (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_idx_i  (wr_idx),
    .wr_data_i (ret_addr),
    .rd_idx_i  (tos_q),
    .rd_data_o (top_data)
  );

  // Stale entries stay in the array after pops, so an empty stack must mask the read.
  assign bus.ras_pcdata_f0_o = cnt_zero ? '0 : top_data;
  assign bus.ras_empty_o     = cnt_zero;
  assign bus.ras_tos_f1_o    = tos_q;
  assign bus.ras_cnt_f1_o    = cnt_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: vector table plus overflow/wrap sequence,
// with expected outputs queued at drive time and compared after the clock edge.
module tb_ras_ctrl;
  import ras_ctrl_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i;

  always #5 clk_i = ~clk_i;

  ras_ctrl_if rif ();

  ras_ctrl dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (rif)
  );

  typedef struct {
    logic        rst;
    logic        brext;
    logic [1:0]  ctl;
    logic [63:0] dat;
    logic        flush;
    logic        rcv;
    logic [3:0]  rtos;
    logic [4:0]  rcnt;
    logic [63:0] exp_pc;
    logic        exp_empty;
    logic [3:0]  exp_tos;
    logic [4:0]  exp_cnt;
    string       name;
  } vec_t;

  localparam int NVEC = 23;

  vec_t vecs [NVEC];
  vec_t sb [$];
  int   tests_run;
  int   tests_failed;

  // Recovery checkpoints above DEPTH are illegal stimulus.
  always @(posedge clk_i) begin
    if (rif.rcv_vld_i === 1'b1) begin
      assert (rif.rcv_cnt_i <= 5'd16)
      else $error("[TB] illegal rcv_cnt_i %0d", rif.rcv_cnt_i);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t mk(input logic rst, input logic brext, input logic [1:0] ctl,
                              input logic [63:0] dat, input logic flush, input logic rcv,
                              input logic [3:0] rtos, input logic [4:0] rcnt,
                              input logic [63:0] exp_pc, input logic exp_empty,
                              input logic [3:0] exp_tos, input logic [4:0] exp_cnt,
                              input string name);
    vec_t v;
    v.rst = rst; v.brext = brext; v.ctl = ctl; v.dat = dat;
    v.flush = flush; v.rcv = rcv; v.rtos = rtos; v.rcnt = rcnt;
    v.exp_pc = exp_pc; v.exp_empty = exp_empty; v.exp_tos = exp_tos; v.exp_cnt = exp_cnt;
    v.name = name;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst_i                 = v.rst;
    rif.brdec_brext_f1_i  = v.brext;
    rif.brdec_rasctl_f1_i = v.ctl;
    rif.brdec_rasdat_f1_i = v.dat;
    rif.flush_vld_i       = v.flush;
    rif.rcv_vld_i         = v.rcv;
    rif.rcv_tos_i         = v.rtos;
    rif.rcv_cnt_i         = v.rcnt;
    sb.push_back(v);
    @(posedge clk_i);
    #1;
  endtask

  task automatic cmp(input string name, input string field, input logic [63:0] got,
                     input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", name, field, got, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard: got no queued expectation, expected one");
      return;
    end
    e = sb.pop_front();
    cmp(e.name, "pc",    rif.ras_pcdata_f0_o,     e.exp_pc);
    cmp(e.name, "empty", 64'(rif.ras_empty_o),    64'(e.exp_empty));
    cmp(e.name, "tos",   64'(rif.ras_tos_f1_o),   64'(e.exp_tos));
    cmp(e.name, "cnt",   64'(rif.ras_cnt_f1_o),   64'(e.exp_cnt));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;

    //            rst brx ctl          dat       fl rcv rtos rcnt  exp_pc    emp tos cnt
    vecs[0]  = mk(1, 0, RAS_NONE,    64'h0,    0, 0, 0, 0,  64'h0,    1, 0,  0, "reset0");
    vecs[1]  = mk(1, 0, RAS_NONE,    64'h0,    0, 0, 0, 0,  64'h0,    1, 0,  0, "reset1");
    vecs[2]  = mk(0, 0, RAS_NONE,    64'h0,    0, 0, 0, 0,  64'h0,    1, 0,  0, "idle");
    vecs[3]  = mk(0, 1, RAS_PUSH,    64'h1000, 0, 0, 0, 0,  64'h1004, 0, 1,  1, "push1000");
    vecs[4]  = mk(0, 1, RAS_PUSH,    64'h2000, 0, 0, 0, 0,  64'h2004, 0, 2,  2, "push2000");
    vecs[5]  = mk(0, 1, RAS_POP,     64'h0,    0, 0, 0, 0,  64'h1004, 0, 1,  1, "pop1");
    vecs[6]  = mk(0, 1, RAS_POP,     64'h0,    0, 0, 0, 0,  64'h0,    1, 0,  0, "pop2");
    vecs[7]  = mk(0, 1, RAS_POP,     64'h0,    0, 0, 0, 0,  64'h0,    1, 0,  0, "pop_empty");
    vecs[8]  = mk(0, 1, RAS_POPPUSH, 64'h5000, 0, 0, 0, 0,  64'h5004, 0, 0,  1, "poppush_empty");
    vecs[9]  = mk(0, 1, RAS_POP,     64'h0,    0, 0, 0, 0,  64'h0,    1, 15, 0, "pop_wrap");
    vecs[10] = mk(0, 1, RAS_PUSH,    64'h1000, 0, 0, 0, 0,  64'h1004, 0, 0,  1, "push_wrap");
    vecs[11] = mk(0, 1, RAS_PUSH,    64'h2000, 0, 0, 0, 0,  64'h2004, 0, 1,  2, "push2");
    vecs[12] = mk(0, 1, RAS_POPPUSH, 64'h3000, 0, 0, 0, 0,  64'h3004, 0, 1,  2, "poppush");
    vecs[13] = mk(0, 1, RAS_PUSH,    64'h7000, 1, 0, 0, 0,  64'h3004, 0, 1,  2, "flush_push");
    vecs[14] = mk(0, 0, RAS_PUSH,    64'h7000, 0, 0, 0, 0,  64'h3004, 0, 1,  2, "no_brext");
    vecs[15] = mk(0, 1, RAS_PUSH,    64'h4000, 0, 0, 0, 0,  64'h4004, 0, 2,  3, "push4000");
    vecs[16] = mk(0, 1, RAS_PUSH,    64'h6000, 0, 0, 0, 0,  64'h6004, 0, 3,  4, "push6000");
    vecs[17] = mk(0, 1, RAS_PUSH,    64'h8000, 0, 1, 3, 3,  64'h6004, 0, 3,  3, "rcv_push");
    vecs[18] = mk(0, 0, RAS_NONE,    64'h0,    1, 1, 1, 2,  64'h3004, 0, 1,  2, "rcv_flush");
    vecs[19] = mk(0, 0, RAS_NONE,    64'h0,    0, 1, 2, 0,  64'h0,    1, 2,  0, "rcv_empty");
    vecs[20] = mk(1, 1, RAS_PUSH,    64'h9000, 0, 1, 5, 5,  64'h0,    1, 0,  0, "rst_rcv_push");
    vecs[21] = mk(0, 0, RAS_NONE,    64'h0,    0, 1, 3, 3,  64'h0,    0, 3,  3, "rcv_after_rst");
    vecs[22] = mk(0, 0, RAS_NONE,    64'h0,    0, 1, 0, 0,  64'h0,    1, 0,  0, "rcv_clear");

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      checkOutput();
    end

    // Overflow: 17 pushes saturate cnt at 16 and overwrite the oldest slot.
    for (int k = 1; k <= 17; k++) begin
      applyStimulus(mk(0, 1, RAS_PUSH, 64'(k) * 64'h100, 0, 0, 0, 0,
                       64'(k) * 64'h100 + 64'h4, 0, 4'(k % 16),
                       (k > 16) ? 5'd16 : 5'(k), "ovf_push"));
      checkOutput();
    end

    // Drain in LIFO order; the overwritten first push is never returned.
    for (int j = 1; j <= 16; j++) begin
      applyStimulus(mk(0, 1, RAS_POP, 64'h0, 0, 0, 0, 0,
                       (j < 16) ? 64'(17 - j) * 64'h100 + 64'h4 : 64'h0,
                       (j == 16), 4'((17 - j) % 16), 5'(16 - j), "ovf_pop"));
      checkOutput();
    end

    // Reset asserted mid-stream while a push is in flight.
    applyStimulus(mk(0, 1, RAS_PUSH, 64'hA000, 0, 0, 0, 0, 64'hA004, 0, 2, 1, "pre_rst_push"));
    checkOutput();
    applyStimulus(mk(1, 1, RAS_PUSH, 64'hB000, 0, 0, 0, 0, 64'h0, 1, 0, 0, "mid_rst"));
    checkOutput();
    applyStimulus(mk(0, 0, RAS_NONE, 64'h0, 0, 1, 2, 1, 64'h0, 0, 2, 1, "rcv_zeroed"));
    checkOutput();

    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
